// File: rtl/udp_traffic_gen_pkg.sv
// ---------------------------------------------------------------------------------------------
// udp_traffic_gen_pkg
//   Shared definitions for the UDP traffic generator: data-pattern mode codes, FSM state
//   encodings, the PRBS seed and small helper functions (length clamp, PRBS8 step).
// ---------------------------------------------------------------------------------------------
package udp_traffic_gen_pkg;

    // Payload pattern selected by i_cfg_mode
    typedef enum logic [1:0] {
        ModeIncr  = 2'd0,
        ModeFixed = 2'd1,
        ModePrbs8 = 2'd2,
        ModeSeq   = 2'd3
    } gen_mode_e;

    // Generator FSM
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StWaitRdy = 3'd1,
        StSend    = 3'd2,
        StGap     = 3'd3,
        StEnd     = 3'd4
    } gen_state_e;

    localparam logic [7:0] PrbsSeed = 8'hFF;

    // Clamp a requested payload length into [min_len, max_len]
    function automatic logic [15:0] clamp_len(input logic [15:0] len,
                                              input logic [15:0] min_len,
                                              input logic [15:0] max_len);
        logic [15:0] res;
        res = len;
        if (len < min_len) begin
            res = min_len;
        end else if (len > max_len) begin
            res = max_len;
        end
        return res;
    endfunction

    // One step of the x^8+x^6+x^5+x^4+1 Fibonacci LFSR; newest bit enters at bit 0
    function automatic logic [7:0] prbs8_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/udp_traffic_gen_prbs8.sv
// ---------------------------------------------------------------------------------------------
// udp_traffic_gen_prbs8
//   8-bit PRBS source for the traffic generator (x^8+x^6+x^5+x^4+1, Fibonacci form).
//   The current register value is the byte presented; it advances once per emitted byte.
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset (register returns to the seed)
//   i_seed_load  reload the seed (start of a run); has priority over i_adv
//   i_adv        step the LFSR after the current byte has been used
//   o_byte       current PRBS byte
// ---------------------------------------------------------------------------------------------
module udp_traffic_gen_prbs8
    import udp_traffic_gen_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_seed_load,
    input  logic       i_adv,
    output logic [7:0] o_byte
);

    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (i_seed_load) begin
            lfsr_d = PrbsSeed;
        end else if (i_adv) begin
            lfsr_d = prbs8_next(lfsr_q);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lfsr_q <= PrbsSeed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign o_byte = lfsr_q;

endmodule

// File: rtl/udp_traffic_gen.sv
// ---------------------------------------------------------------------------------------------
// udp_traffic_gen
//   On-chip UDP payload load generator feeding the stack user-TX port. A run emits
//   i_cfg_num packets (0 = until i_stop) of clamped length, separated by a configurable
//   idle gap, with one of four payload patterns (INCR, FIXED, PRBS8, SEQ).
// Ports
//   i_clk, i_rst_n       clock (rising edge) and asynchronous active-low reset
//   i_start              pulse: latch configuration and begin a run (ignored while busy)
//   i_stop               pulse: finish the current packet and gap, then end the run
//   i_cfg_len/gap/num    payload length, inter-packet gap cycles, packets per run
//   i_cfg_mode           payload pattern
//   i_send_ready         stack can take a new packet (only looked at between packets)
//   o_send_udp_*         payload byte, clamped length, last flag, byte valid
//   o_busy, o_done       run in progress; one-cycle pulse when the run ends
//   o_pkt_cnt            packets completed in the current / last run (saturating)
// ---------------------------------------------------------------------------------------------
module udp_traffic_gen
    import udp_traffic_gen_pkg::*;
#(
    parameter int unsigned P_MIN_LEN = 18,
    parameter int unsigned P_MAX_LEN = 1472,
    parameter int unsigned P_GAP_W   = 16,
    parameter int unsigned P_CNT_W   = 32,
    parameter logic [7:0]  P_FILL    = 8'hA5
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic [15:0]        i_cfg_len,
    input  logic [P_GAP_W-1:0] i_cfg_gap,
    input  logic [P_CNT_W-1:0] i_cfg_num,
    input  logic [1:0]         i_cfg_mode,
    input  logic               i_send_ready,
    output logic [7:0]         o_send_udp_data,
    output logic [15:0]        o_send_udp_len,
    output logic               o_send_udp_last,
    output logic               o_send_udp_valid,
    output logic               o_busy,
    output logic               o_done,
    output logic [P_CNT_W-1:0] o_pkt_cnt
);

    localparam logic [15:0]        MinLen = 16'(P_MIN_LEN);
    localparam logic [15:0]        MaxLen = 16'(P_MAX_LEN);
    localparam logic [P_GAP_W-1:0] GapOne = P_GAP_W'(1);
    localparam logic [P_CNT_W-1:0] CntOne = P_CNT_W'(1);

    gen_state_e         state_q, state_d;
    gen_mode_e          mode_q, mode_d;
    logic [15:0]        len_q, len_d;
    logic [P_GAP_W-1:0] gap_cfg_q, gap_cfg_d;
    logic [P_GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [P_CNT_W-1:0] num_q, num_d;
    logic [P_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [15:0]        byte_idx_q, byte_idx_d;
    logic               stop_pend_q, stop_pend_d;

    logic               start_acc;
    logic               sending;
    logic               is_last;
    logic               stop_seen;
    logic [P_CNT_W-1:0] cnt_inc;
    logic               end_after_send;
    logic               end_after_gap;
    logic [7:0]         prbs_byte;
    logic [7:0]         byte_val;
    logic [31:0]        seq_word;
    logic [15:0]        seq_off;

    assign start_acc = (state_q == StIdle) && i_start;
    assign sending   = (state_q == StSend);
    assign is_last   = (byte_idx_q == len_q - 16'd1);
    assign stop_seen = stop_pend_q || i_stop;

    // Completed-packet count never wraps in continuous mode
    assign cnt_inc = (pkt_cnt_q != '1) ? pkt_cnt_q + CntOne : pkt_cnt_q;

    // With a zero gap the end-of-run decision is taken on the last byte itself, so it must
    // use the count as it will be after this packet.
    assign end_after_send = stop_seen || ((num_q != '0) && (cnt_inc == num_q));
    assign end_after_gap  = stop_seen || ((num_q != '0) && (pkt_cnt_q == num_q));

    // -----------------------------------------------------------------------------------------
    // FSM next state and counters
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        len_d       = len_q;
        gap_cfg_d   = gap_cfg_q;
        gap_cnt_d   = gap_cnt_q;
        num_d       = num_q;
        pkt_cnt_d   = pkt_cnt_q;
        byte_idx_d  = byte_idx_q;
        stop_pend_d = stop_pend_q;

        case (state_q)
            StIdle: begin
                // A coincident i_stop is deliberately dropped here
                if (i_start) begin
                    mode_d      = gen_mode_e'(i_cfg_mode);
                    len_d       = clamp_len(i_cfg_len, MinLen, MaxLen);
                    gap_cfg_d   = i_cfg_gap;
                    num_d       = i_cfg_num;
                    pkt_cnt_d   = '0;
                    byte_idx_d  = '0;
                    gap_cnt_d   = '0;
                    stop_pend_d = 1'b0;
                    state_d     = StWaitRdy;
                end
            end

            StWaitRdy: begin
                if (i_stop) begin
                    state_d = StEnd;
                end else if (i_send_ready) begin
                    byte_idx_d = '0;
                    state_d    = StSend;
                end
            end

            StSend: begin
                if (i_stop) begin
                    stop_pend_d = 1'b1;
                end
                if (is_last) begin
                    byte_idx_d = '0;
                    pkt_cnt_d  = cnt_inc;
                    gap_cnt_d  = '0;
                    if (gap_cfg_q != '0) begin
                        state_d = StGap;
                    end else if (end_after_send) begin
                        state_d = StEnd;
                    end else begin
                        state_d = StWaitRdy;
                    end
                end else begin
                    byte_idx_d = byte_idx_q + 16'd1;
                end
            end

            StGap: begin
                if (i_stop) begin
                    stop_pend_d = 1'b1;
                end
                if (gap_cnt_q == gap_cfg_q - GapOne) begin
                    state_d = end_after_gap ? StEnd : StWaitRdy;
                end else begin
                    gap_cnt_d = gap_cnt_q + GapOne;
                end
            end

            StEnd: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            mode_q      <= ModeIncr;
            len_q       <= '0;
            gap_cfg_q   <= '0;
            gap_cnt_q   <= '0;
            num_q       <= '0;
            pkt_cnt_q   <= '0;
            byte_idx_q  <= '0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            len_q       <= len_d;
            gap_cfg_q   <= gap_cfg_d;
            gap_cnt_q   <= gap_cnt_d;
            num_q       <= num_d;
            pkt_cnt_q   <= pkt_cnt_d;
            byte_idx_q  <= byte_idx_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Payload pattern
    // -----------------------------------------------------------------------------------------
    // PRBS is reseeded per run and keeps running across packets of that run
    udp_traffic_gen_prbs8 u_prbs8 (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_seed_load (start_acc),
        .i_adv       (sending),
        .o_byte      (prbs_byte)
    );

    assign seq_word = 32'(pkt_cnt_q);
    assign seq_off  = byte_idx_q - 16'd4;

    always_comb begin
        byte_val = '0;
        case (mode_q)
            ModeIncr:  byte_val = byte_idx_q[7:0];
            ModeFixed: byte_val = P_FILL;
            ModePrbs8: byte_val = prbs_byte;
            ModeSeq: begin
                // Big-endian sequence number of this packet, then an INCR tail from 0
                if (byte_idx_q < 16'd4) begin
                    case (byte_idx_q[1:0])
                        2'd0:    byte_val = seq_word[31:24];
                        2'd1:    byte_val = seq_word[23:16];
                        2'd2:    byte_val = seq_word[15:8];
                        default: byte_val = seq_word[7:0];
                    endcase
                end else begin
                    byte_val = seq_off[7:0];
                end
            end
            default: byte_val = '0;
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------------------------
    assign o_send_udp_valid = sending;
    assign o_send_udp_last  = sending && is_last;
    assign o_send_udp_data  = sending ? byte_val : 8'h00;
    assign o_send_udp_len   = len_q;
    assign o_busy           = (state_q != StIdle);
    assign o_done           = (state_q == StEnd);
    assign o_pkt_cnt        = pkt_cnt_q;

endmodule

// File: tb/tb_udp_traffic_gen.sv
module tb_udp_traffic_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop;
    logic [15:0] cfg_len;
    logic [15:0] cfg_gap;
    logic [31:0] cfg_num;
    logic [1:0]  cfg_mode;
    logic        send_ready;
    logic [7:0]  data;
    logic [15:0] len_o;
    logic        last, valid, busy, done;
    logic [31:0] pkt_cnt;

    always #5 clk = ~clk;

    udp_traffic_gen dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_start          (start),
        .i_stop           (stop),
        .i_cfg_len        (cfg_len),
        .i_cfg_gap        (cfg_gap),
        .i_cfg_num        (cfg_num),
        .i_cfg_mode       (cfg_mode),
        .i_send_ready     (send_ready),
        .o_send_udp_data  (data),
        .o_send_udp_len   (len_o),
        .o_send_udp_last  (last),
        .o_send_udp_valid (valid),
        .o_busy           (busy),
        .o_done           (done),
        .o_pkt_cnt        (pkt_cnt)
    );

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every valid byte with its cycle stamp, plus a count of done pulses
    logic [7:0]  act_data[$];
    bit          act_last[$];
    int          act_cyc[$];
    logic [15:0] act_len[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            act_data.push_back(data);
            act_last.push_back(last);
            act_cyc.push_back(cyc);
            act_len.push_back(len_o);
        end
        if (done === 1'b1) done_cnt++;
    end

    // ------------------------------------------------------------------ reference model
    logic [7:0] exp_data[$];
    bit         exp_last[$];
    bit         prbs_bits[$];

    function automatic int clamp(input int l);
        if (l < 18) return 18;
        if (l > 1472) return 1472;
        return l;
    endfunction

    // PRBS as a bit sequence: x[k] = x[k-8]^x[k-6]^x[k-5]^x[k-4], seeded with eight ones;
    // byte j is x[j..j+7], oldest bit in the MSB.
    function automatic logic [7:0] prbs_byte(input int j);
        logic [7:0] v;
        while (prbs_bits.size() < j + 8) begin
            int n;
            n = prbs_bits.size();
            prbs_bits.push_back(prbs_bits[n-8] ^ prbs_bits[n-6] ^ prbs_bits[n-5] ^ prbs_bits[n-4]);
        end
        for (int i = 0; i < 8; i++) v[7-i] = prbs_bits[j+i];
        return v;
    endfunction

    function automatic void model_run(input int len_cfg, input int npkts, input int mode);
        int l;
        logic [7:0] v;
        l = clamp(len_cfg);
        exp_data.delete();
        exp_last.delete();
        prbs_bits.delete();
        for (int i = 0; i < 8; i++) prbs_bits.push_back(1'b1);
        for (int p = 0; p < npkts; p++) begin
            for (int b = 0; b < l; b++) begin
                case (mode)
                    0:       v = 8'(b % 256);
                    1:       v = 8'hA5;
                    2:       v = prbs_byte(p * l + b);
                    default: v = (b < 4) ? 8'((p >> (8 * (3 - b))) & 255) : 8'((b - 4) % 256);
                endcase
                exp_data.push_back(v);
                exp_last.push_back(b == l - 1);
            end
        end
    endfunction

    // -1: stream matches model; -2: length differs; else index of first bad byte
    function automatic int first_diff(input int base, input int exp_len);
        if (act_data.size() - base != exp_data.size()) return -2;
        for (int i = 0; i < exp_data.size(); i++) begin
            if (act_data[base+i] !== exp_data[i] || act_last[base+i] !== exp_last[i] ||
                act_len[base+i] !== 16'(exp_len)) return i;
        end
        return -1;
    endfunction

    // ------------------------------------------------------------------ drivers
    task automatic start_run(input int len_v, input int gap_v, input int num_v, input int mode_v,
                             input bit with_stop);
        @(negedge clk);
        cfg_len  = 16'(len_v);
        cfg_gap  = 16'(gap_v);
        cfg_num  = 32'(num_v);
        cfg_mode = 2'(mode_v);
        start    = 1'b1;
        stop     = with_stop;
        @(negedge clk);
        start    = 1'b0;
        stop     = 1'b0;
        // Scribble over the config: the running generator must ignore it
        cfg_len  = 16'($urandom);
        cfg_gap  = 16'($urandom);
        cfg_num  = $urandom;
        cfg_mode = 2'($urandom);
    endtask

    task automatic wait_done(input int done_base, input int budget, input bit rand_rdy,
                             output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n < budget) begin
            @(negedge clk);
            if (rand_rdy) send_ready = 1'($urandom_range(0, 1));
            if (done_cnt > done_base) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        repeat (3) @(negedge clk);
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; send_ready = 1'b0;
        cfg_len = '0; cfg_gap = '0; cfg_num = '0; cfg_mode = '0;
        repeat (3) @(negedge clk);
        tests++;
        if ({valid, last, busy, done} !== 4'b0) begin
            failed++;
            $display("FAIL reset_flags: got %b want 0000", {valid, last, busy, done});
        end
        tests++;
        if (pkt_cnt !== 32'd0) begin
            failed++; $display("FAIL reset_pkt_cnt: got %0d want 0", pkt_cnt);
        end
        tests++;
        if (len_o !== 16'd0) begin
            failed++; $display("FAIL reset_len: got %0d want 0", len_o);
        end
        tests++;
        if (data !== 8'd0) begin
            failed++; $display("FAIL reset_data: got %0h want 0", data);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            failed++; $display("FAIL reset_release_idle: busy %b valid %b want 0 0", busy, valid);
        end
    endtask

    task automatic test_incr_single();
        int base, db, d;
        bit ok;
        send_ready = 1'b1;
        base = act_data.size();
        db   = done_cnt;
        model_run(100, 1, 0);
        start_run(100, 0, 1, 0, 1'b0);
        wait_done(db, 400, 1'b0, ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL incr_timeout: got no done want done"); end
        tests++;
        if (act_data.size() - base != 100) begin
            failed++; $display("FAIL incr_count: got %0d want 100", act_data.size() - base);
        end
        d = first_diff(base, 100);
        tests++;
        if (d != -1) begin failed++; $display("FAIL incr_stream: first_diff %0d want -1", d); end
        tests++;
        if (done_cnt - db != 1) begin
            failed++; $display("FAIL incr_done_pulses: got %0d want 1", done_cnt - db);
        end
        tests++;
        if (pkt_cnt !== 32'd1) begin failed++; $display("FAIL incr_pkt_cnt: got %0d want 1", pkt_cnt); end
        tests++;
        if (busy !== 1'b0) begin failed++; $display("FAIL incr_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_seq_gap();
        int base, db, d, bad;
        bit ok;
        send_ready = 1'b1;
        base = act_data.size();
        db   = done_cnt;
        model_run(10, 3, 3);
        start_run(10, 5, 3, 3, 1'b0);
        wait_done(db, 400, 1'b0, ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL seq_timeout: got no done want done"); end
        d = first_diff(base, 18);
        tests++;
        if (d != -1) begin failed++; $display("FAIL seq_stream: first_diff %0d want -1", d); end
        bad = 0;
        if (act_data.size() - base == 54) begin
            for (int i = 1; i < 54; i++) begin
                if (i % 18 == 0) begin
                    if (act_cyc[base+i] - act_cyc[base+i-1] != 7) bad++;
                end else if (act_cyc[base+i] - act_cyc[base+i-1] != 1) bad++;
            end
        end else begin
            bad = 99;
        end
        tests++;
        if (bad != 0) begin failed++; $display("FAIL seq_spacing: got %0d bad gaps want 0", bad); end
        tests++;
        if (pkt_cnt !== 32'd3) begin failed++; $display("FAIL seq_pkt_cnt: got %0d want 3", pkt_cnt); end
    endtask

    task automatic test_clamp();
        int lens[2];
        int base, db, d;
        bit ok;
        lens[0] = 5;
        lens[1] = 2000;
        send_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            base = act_data.size();
            db   = done_cnt;
            model_run(lens[k], 1, 0);
            start_run(lens[k], 0, 1, 0, 1'b0);
            wait_done(db, 2000, 1'b0, ok);
            tests++;
            if (len_o !== 16'(clamp(lens[k]))) begin
                failed++; $display("FAIL clamp_len_%0d: got %0d want %0d", lens[k], len_o, clamp(lens[k]));
            end
            tests++;
            if (act_data.size() - base != clamp(lens[k])) begin
                failed++;
                $display("FAIL clamp_count_%0d: got %0d want %0d", lens[k], act_data.size() - base,
                         clamp(lens[k]));
            end
            d = first_diff(base, clamp(lens[k]));
            tests++;
            if (d != -1) begin failed++; $display("FAIL clamp_stream_%0d: first_diff %0d want -1", lens[k], d); end
        end
    endtask

    task automatic test_ready_low();
        int base, db, d, r;
        bit ok;
        send_ready = 1'b0;
        base = act_data.size();
        db   = done_cnt;
        model_run(20, 1, 0);
        start_run(20, 0, 1, 0, 1'b0);
        repeat (50) @(negedge clk);
        tests++;
        if (act_data.size() != base || busy !== 1'b1) begin
            failed++;
            $display("FAIL ready_low_hold: got %0d bytes busy %b want 0 bytes busy 1",
                     act_data.size() - base, busy);
        end
        send_ready = 1'b1;
        r = cyc;
        wait_done(db, 200, 1'b0, ok);
        d = first_diff(base, 20);
        tests++;
        if (d != -1) begin failed++; $display("FAIL ready_low_stream: first_diff %0d want -1", d); end
        tests++;
        if (act_data.size() == base || act_cyc[base] != r + 1) begin
            failed++;
            $display("FAIL ready_low_latency: got cycle %0d want %0d",
                     (act_data.size() == base) ? -1 : act_cyc[base], r + 1);
        end
    endtask

    task automatic test_stop_corner();
        int base, db, d;
        bit ok;
        // Stop while waiting for ready: run ends without a packet
        send_ready = 1'b0;
        base = act_data.size();
        db   = done_cnt;
        start_run(20, 0, 5, 0, 1'b0);
        repeat (3) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_done(db, 50, 1'b0, ok);
        tests++;
        if (!ok || act_data.size() != base || pkt_cnt !== 32'd0) begin
            failed++;
            $display("FAIL stop_in_wait: done %b bytes %0d cnt %0d want 1 0 0", ok,
                     act_data.size() - base, pkt_cnt);
        end
        // Start and stop together in idle: start wins, stop forgotten
        send_ready = 1'b1;
        base = act_data.size();
        db   = done_cnt;
        model_run(18, 2, 1);
        start_run(18, 1, 2, 1, 1'b1);
        wait_done(db, 200, 1'b0, ok);
        d = first_diff(base, 18);
        tests++;
        if (d != -1) begin failed++; $display("FAIL start_stop_same: first_diff %0d want -1", d); end
        tests++;
        if (pkt_cnt !== 32'd2) begin failed++; $display("FAIL start_stop_cnt: got %0d want 2", pkt_cnt); end
    endtask

    task automatic test_prbs_stop();
        int base, db, d, l, g, n;
        bit ok;
        l = $urandom_range(18, 40);
        g = $urandom_range(0, 3);
        send_ready = 1'b1;
        base = act_data.size();
        db   = done_cnt;
        model_run(l, 2, 2);
        start_run(l, g, 0, 2, 1'b0);
        n = 0;
        while (act_data.size() - base < l + l / 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_done(db, 300, 1'b0, ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL prbs_stop_timeout: got no done want done"); end
        d = first_diff(base, l);
        tests++;
        if (d != -1) begin failed++; $display("FAIL prbs_stream: first_diff %0d want -1 (len %0d)", d, l); end
        tests++;
        if (pkt_cnt !== 32'd2 || done_cnt - db != 1) begin
            failed++;
            $display("FAIL prbs_stop_cnt: cnt %0d done %0d want 2 1", pkt_cnt, done_cnt - db);
        end
    endtask

    task automatic test_reset_mid();
        int base, db, d, n;
        bit ok;
        send_ready = 1'b1;
        base = act_data.size();
        start_run(100, 0, 1, 0, 1'b0);
        n = 0;
        while (act_data.size() - base < 40 && n < 200) begin
            @(negedge clk);
            n++;
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({valid, last, busy} !== 3'b0) begin
            failed++; $display("FAIL reset_mid_outputs: got %b want 000", {valid, last, busy});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (pkt_cnt !== 32'd0) begin failed++; $display("FAIL reset_mid_cnt: got %0d want 0", pkt_cnt); end
        base = act_data.size();
        db   = done_cnt;
        model_run(30, 1, 0);
        start_run(30, 0, 1, 0, 1'b0);
        wait_done(db, 200, 1'b0, ok);
        d = first_diff(base, 30);
        tests++;
        if (d != -1) begin failed++; $display("FAIL reset_mid_restart: first_diff %0d want -1", d); end
    endtask

    task automatic test_random();
        int base, db, d, l, g, np, m, bad;
        bit ok;
        for (int it = 0; it < 6; it++) begin
            m  = $urandom_range(0, 3);
            l  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 17) : $urandom_range(18, 60);
            g  = $urandom_range(0, 4);
            np = $urandom_range(1, 3);
            send_ready = 1'($urandom_range(0, 1));
            base = act_data.size();
            db   = done_cnt;
            model_run(l, np, m);
            start_run(l, g, np, m, 1'b0);
            wait_done(db, 2000, 1'b1, ok);
            d = first_diff(base, clamp(l));
            tests++;
            if (!ok || d != -1) begin
                failed++;
                $display("FAIL random_%0d: done %b first_diff %0d want 1 -1 (mode %0d len %0d n %0d)",
                         it, ok, d, m, l, np);
            end
            bad = 0;
            if (d == -1) begin
                for (int i = 1; i < np * clamp(l); i++) begin
                    if (i % clamp(l) == 0) begin
                        if (act_cyc[base+i] - act_cyc[base+i-1] < g + 2) bad++;
                    end else if (act_cyc[base+i] - act_cyc[base+i-1] != 1) bad++;
                end
            end
            tests++;
            if (bad != 0 || pkt_cnt !== 32'(np)) begin
                failed++;
                $display("FAIL random_timing_%0d: bad %0d cnt %0d want 0 %0d", it, bad, pkt_cnt, np);
            end
        end
        send_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_incr_single();
        test_seq_gap();
        test_clamp();
        test_ready_low();
        test_stop_corner();
        test_prbs_stop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
